// File: rtl/kda_pkg.sv
// Shared constants, header field layout, FSM state type and request word mux
// for the KDA host link.
package kda_pkg;

    localparam int WORDS_REQ    = 17;
    localparam int WORDS_RESP   = 16;
    localparam int MAX_SALT_LEN = 50;

    localparam int CHUNKS_MSB   = 63;
    localparam int CHUNKS_LSB   = 62;
    localparam int SALT_LEN_MSB = 61;
    localparam int SALT_LEN_LSB = 56;
    localparam int ITERS_MSB    = 31;
    localparam int ITERS_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_DONE
    } kda_host_state_e;

    // Word 0 is the header, 1..8 walk the password MSW first, 9..16 the salt.
    function automatic logic [63:0] req_word(
        input logic [4:0]   idx,
        input logic [1:0]   chunks,
        input logic [5:0]   salt_len,
        input logic [31:0]  iters,
        input logic [511:0] pass,
        input logic [511:0] salt
    );
        logic [63:0]  w;
        logic [4:0]   k;
        logic [511:0] sh;
        w  = '0;
        k  = '0;
        sh = '0;
        if (idx == 5'd0) begin
            w[CHUNKS_MSB:CHUNKS_LSB]     = chunks;
            w[SALT_LEN_MSB:SALT_LEN_LSB] = salt_len;
            w[ITERS_MSB:ITERS_LSB]       = iters;
        end else if (idx <= 5'd8) begin
            k  = idx - 5'd1;
            sh = pass << {k[2:0], 6'b0};
            w  = sh[511:448];
        end else begin
            k  = idx - 5'd9;
            sh = salt << {k[2:0], 6'b0};
            w  = sh[511:448];
        end
        return w;
    endfunction

endpackage

// File: rtl/kda_req_serializer.sv
// Holds the accepted request and streams it as 17 registered 64-bit words
// under a valid/ready handshake.
module kda_req_serializer
    import kda_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [1:0]   chunks,
    input  logic [5:0]   salt_len,
    input  logic [31:0]  iters,
    input  logic [511:0] pass,
    input  logic [511:0] salt,
    input  logic         kda_ready,
    output logic [63:0]  kda_data,
    output logic         kda_v,
    output logic         first_xfer,
    output logic         last_xfer,
    output logic [1:0]   chunks_held
);

    logic [1:0]   chunks_reg;
    logic [5:0]   salt_len_reg;
    logic [31:0]  iters_reg;
    logic [511:0] pass_reg;
    logic [511:0] salt_reg;
    logic [4:0]   idx_reg;
    logic [63:0]  data_reg;
    logic         v_reg;
    logic         xfer;

    assign xfer        = v_reg & kda_ready;
    assign first_xfer  = xfer & (idx_reg == 5'd0);
    assign last_xfer   = xfer & (idx_reg == 5'(WORDS_REQ - 1));
    assign kda_data    = data_reg;
    assign kda_v       = v_reg;
    assign chunks_held = chunks_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunks_reg   <= '0;
            salt_len_reg <= '0;
            iters_reg    <= '0;
            pass_reg     <= '0;
            salt_reg     <= '0;
            idx_reg      <= '0;
            data_reg     <= '0;
            v_reg        <= 1'b0;
        end else if (load) begin
            chunks_reg   <= chunks;
            salt_len_reg <= salt_len;
            iters_reg    <= iters;
            pass_reg     <= pass;
            salt_reg     <= salt;
            idx_reg      <= '0;
            // Header comes straight from the request so it is ready the next cycle.
            data_reg     <= req_word(5'd0, chunks, salt_len, iters, pass, salt);
            v_reg        <= 1'b1;
        end else if (xfer) begin
            if (last_xfer) begin
                v_reg    <= 1'b0;
                data_reg <= '0;
            end else begin
                idx_reg  <= idx_reg + 5'd1;
                data_reg <= req_word(idx_reg + 5'd1, chunks_reg, salt_len_reg,
                                     iters_reg, pass_reg, salt_reg);
            end
        end
    end

endmodule

// File: rtl/kda_host_link.sv
// Client-side KDA link: accepts one PBKDF2 job, streams it to the KDA core,
// gathers the 16-word response and presents it as a 1024-bit result.
module kda_host_link
    import kda_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic [1:0]    req_chunks_i,
    input  logic [5:0]    req_salt_len_i,
    input  logic [31:0]   req_iters_i,
    input  logic [511:0]  req_pass_i,
    input  logic [511:0]  req_salt_i,
    input  logic          req_v_i,
    output logic          req_ready_o,
    output logic [63:0]   kda_data_o,
    output logic          kda_v_o,
    input  logic          kda_ready_i,
    input  logic [63:0]   kda_data_i,
    input  logic          kda_v_i,
    output logic          kda_yumi_o,
    output logic [1023:0] hash_o,
    output logic          err_o,
    output logic [31:0]   lat_o,
    output logic          resp_v_o,
    input  logic          resp_yumi_i
);

    logic [1:0]      rst_sync_reg;
    logic            rst_n;
    kda_host_state_e state_reg;
    logic            req_ready_reg;
    logic            resp_v_reg;
    logic            err_reg;
    logic [31:0]     lat_reg;
    logic [3:0]      recv_idx_reg;
    logic [63:0]     hash_words [WORDS_RESP];
    logic            accept;
    logic            reject;
    logic            load;
    logic            take;
    logic            take_last;
    logic            first_xfer;
    logic            last_xfer;
    logic [1:0]      chunks_held;

    // Assert immediately, release two clocks after reset_n_i rises.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync_reg <= '0;
        else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    assign accept    = req_ready_reg & req_v_i;
    assign reject    = req_salt_len_i > 6'(MAX_SALT_LEN);
    assign load      = accept & ~reject;
    assign take      = (state_reg == ST_RECV) & kda_v_i;
    assign take_last = take & (recv_idx_reg == 4'(WORDS_RESP - 1));

    assign req_ready_o = req_ready_reg;
    assign kda_yumi_o  = take;
    assign resp_v_o    = resp_v_reg;
    assign err_o       = err_reg;
    assign lat_o       = lat_reg;

    kda_req_serializer u_ser (
        .clk         (clk_i),
        .rst_n       (rst_n),
        .load        (load),
        .chunks      (req_chunks_i),
        .salt_len    (req_salt_len_i),
        .iters       (req_iters_i),
        .pass        (req_pass_i),
        .salt        (req_salt_i),
        .kda_ready   (kda_ready_i),
        .kda_data    (kda_data_o),
        .kda_v       (kda_v_o),
        .first_xfer  (first_xfer),
        .last_xfer   (last_xfer),
        .chunks_held (chunks_held)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            resp_v_reg    <= 1'b0;
            err_reg       <= 1'b0;
            lat_reg       <= '0;
            recv_idx_reg  <= '0;
        end else begin
            if (first_xfer)
                lat_reg <= '0;
            else if ((state_reg == ST_SEND || state_reg == ST_RECV) && lat_reg != '1)
                lat_reg <= lat_reg + 32'd1;

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        err_reg       <= reject;
                        if (reject) begin
                            state_reg  <= ST_DONE;
                            resp_v_reg <= 1'b1;
                        end else begin
                            state_reg  <= ST_SEND;
                        end
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (last_xfer) begin
                        state_reg    <= ST_RECV;
                        recv_idx_reg <= '0;
                    end
                end
                ST_RECV: begin
                    if (take) begin
                        recv_idx_reg <= recv_idx_reg + 4'd1;
                        if (take_last) begin
                            state_reg  <= ST_DONE;
                            resp_v_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (resp_yumi_i) begin
                        resp_v_reg    <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Word gi lives at hash_o[1023-64*gi -: 64]; words 4c..4c+3 form chunk c.
    for (genvar gi = 0; gi < WORDS_RESP; gi++) begin : g_word
        localparam logic [3:0] WORD_IDX = 4'(gi);
        localparam logic [1:0] CHUNK    = 2'(gi / 4);

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n)
                hash_words[gi] <= '0;
            else if (accept)
                hash_words[gi] <= '0;
            else if (take_last && CHUNK > chunks_held)
                hash_words[gi] <= '0;
            else if (take && recv_idx_reg == WORD_IDX)
                hash_words[gi] <= kda_data_i;
        end

        assign hash_o[1023 - 64*gi -: 64] = hash_words[gi];
    end

endmodule

// File: doc/kda_host_link.md
Name: kda_host_link

Overview:
- Client-side counterpart of the KDA core's 64-bit streaming interface.
- Accepts one parallel PBKDF2 job from a client and serializes it into the 17-word KDA request stream. Then collects the 16-word KDA response and presents it to the client as one 1024-bit result.
- Sits between a host/CSR front end and the kda top level. One job in flight at a time.

Parameters:
- WORDS_REQ, 17, request words per job (1 header + 8 pass + 8 salt); fixed, not for override.
- WORDS_RESP, 16, response words per job (1024 bits); fixed, not for override.
- MAX_SALT_LEN, 50, largest legal salt_len; larger values are rejected locally.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_chunks_i  in  2  number of 256-bit output chunks minus 1
- req_salt_len_i  in  6  salt length in bytes
- req_iters_i  in  32  iteration count
- req_pass_i  in  512  password, left-aligned
- req_salt_i  in  512  salt, left-aligned
- req_v_i  in  1  request valid
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o
- kda_data_o  out  64  request word to KDA
- kda_v_o  out  1  request word valid
- kda_ready_i  in  1  KDA accepts; transfer on kda_v_o & kda_ready_i
- kda_data_i  in  64  response word from KDA
- kda_v_i  in  1  response word valid
- kda_yumi_o  out  1  response word consumed this cycle
- hash_o  out  1024  collected result; unused chunks zeroed
- err_o  out  1  result is a local rejection (salt_len > MAX_SALT_LEN)
- lat_o  out  32  cycles from first request word sent to last response word taken (saturating)
- resp_v_o  out  1  result valid
- resp_yumi_i  in  1  client consumes result; legal only while resp_v_o

Behaviour:
- Reset (async assert, sync deassert inside block):
  - State = IDLE; all counters 0; hash_o, err_o, lat_o = 0.
  - req_ready_o, kda_v_o, kda_yumi_o, resp_v_o = 0.
  - kda_data_o = 0.
- Reset mid-job abandons the job. Restarting the KDA side is the system's responsibility.
- States: IDLE, SEND, RECV, DONE.
- IDLE:
  - req_ready_o = 1.
  - On req_v_i, all request fields are registered.
  - If req_salt_len_i > MAX_SALT_LEN: hash_o = 0, err_o = 1, go to DONE.
  - Otherwise: err_o = 0, send index = 0, go to SEND.
- SEND:
  - kda_v_o = 1.
  - kda_data_o comes from a registered mux on the send index:
    - word 0 = {chunks[1:0], salt_len[5:0], 24'b0, iters[31:0]}
    - words 1..8 = pass[511:448] down to pass[63:0]
    - words 9..16 = salt[511:448] down to salt[63:0]
  - Index increments only on kda_v_o & kda_ready_i. kda_v_o and the data word hold stable while ready is low.
  - Transfer of word 16 → go to RECV, receive index = 0.
  - lat_o counter clears on the cycle word 0 transfers and increments every cycle after, saturating at 32'hFFFF_FFFF.
- RECV:
  - kda_yumi_o = kda_v_i, combinational. It is never asserted outside RECV.
  - Each consumed word is written to hash_o[1023-64*idx -: 64]; index increments.
  - Consuming word 15 → go to DONE.
  - On that same edge, chunk slices above req_chunks are zeroed:
    - chunks = 0 keeps [1023:768]
    - chunks = 1 keeps [1023:512]
    - chunks = 2 keeps [1023:256]
    - chunks = 3 keeps all
  - lat_o freezes on that edge.
- DONE:
  - resp_v_o = 1; hash_o, err_o, lat_o stable.
  - resp_yumi_i → IDLE next cycle.
  - req_ready_o is low in DONE, so there is a one-cycle bubble between jobs.
- KDA response words arriving during IDLE/SEND/DONE are left unconsumed (no yumi).
- req_v_i may drop without acceptance; no state change.
- Throughput: at most 1 request word per cycle; 17 cycles minimum for SEND.

Decomposition:
- Package kda_pkg:
  - Header field positions: CHUNKS_MSB/LSB, SALT_LEN_MSB/LSB, ITERS_MSB/LSB.
  - WORDS_REQ, WORDS_RESP, MAX_SALT_LEN.
  - State enum kda_host_state_e.
- One natural sub-module: kda_req_serializer, which holds the request register, the send index and the word mux with the valid/ready handshake. Response collection and the FSM stay in the top.

Test Plan:
- Nominal, chunks=3, salt_len=8, iters=1000, kda_ready_i=1, scripted response words 0x1..0x10 → word0 = 0xC800_0000_0000_03E8. 17 back-to-back transfers, then hash_o[1023:960]=0x1 … hash_o[63:0]=0x10, err_o=0, resp_v_o=1.
- chunks=0, same response → hash_o[767:0]=0, upper 256 bits intact.
- Backpressure: kda_ready_i toggles 1 cycle on / 2 off → kda_data_o and kda_v_o stable while stalled, exactly 17 words sent in order, no duplicates.
- salt_len=51 → no kda_v_o ever, resp_v_o=1 one cycle after accept, err_o=1, hash_o=0.
- Response gaps: kda_v_i pulses every 3rd cycle; response word arrives while in SEND → no yumi until RECV. lat_o equals the scoreboard's cycle count.
- Async reset asserted mid-SEND at word 5 → outputs 0 immediately. After release, req_ready_o=1 and a new job starts at word 0.
